iot_frame_sched: RTL
====================

IOT_FRAME_SCHED -- requirements
Module: iot_frame_sched

Interface
REQ-001 SHALL have parameter FRAMES, default 96, number of 128-bit frames per round (2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_en  input  1  byte-valid from source.
REQ-005 SHALL have port iot_in  input  8  input byte; first byte of a frame is bits [127:120].
REQ-006 SHALL have port fn_sel  input  3  filter function select, sampled per round.
REQ-007 SHALL have port frame_rdy  input  1  filter datapath accepts the presented frame.
REQ-008 SHALL have port busy  output  1  source must hold the byte; a byte is taken only when in_en=1 and busy=0.
REQ-009 SHALL have port frame_vld  output  1  frame_data valid for the filter datapath.
REQ-010 SHALL have port frame_data  output  128  assembled frame.
REQ-011 SHALL have port frame_idx  output  8  index (0..FRAMES-1) of the presented frame.
REQ-012 SHALL have port last_frame  output  1  high with frame_vld when frame_idx=FRAMES-1.
REQ-013 SHALL have port fn_cur  output  3  fn_sel latched for the current round.
REQ-014 SHALL have port round_done  output  1  one-cycle pulse at round end.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, ISSUE, DONE.
REQ-016 IDLE: first accepted byte latches fn_cur from fn_sel, stores the byte in [127:120], sets byte count to 1 and moves to COLLECT.
REQ-017 COLLECT: each accepted byte fills the next lower byte lane; the 16th byte moves to ISSUE and frame_vld SHALL be high on the following cycle (1-cycle latency).
REQ-018 ISSUE: frame_vld, frame_data, frame_idx and last_frame SHALL stay stable until the cycle frame_vld=1 and frame_rdy=1; the transfer happens on that edge.
REQ-019 After a transfer with frame_idx<FRAMES-1, frame_idx SHALL increment and the FSM SHALL return to COLLECT (or stay in ISSUE when a buffered frame is ready, see Configuration).
REQ-020 After a transfer with frame_idx=FRAMES-1, the FSM SHALL go to DONE, assert round_done for exactly one cycle, clear frame_idx to 0 and return to IDLE.
REQ-021 busy SHALL be 1 in ISSUE and DONE and 0 in IDLE and COLLECT (non-buffered build).
REQ-022 A byte presented with in_en=1 while busy=1 SHALL be ignored and not counted.
REQ-023 in_en=0 gaps inside a frame SHALL pause assembly without loss or reordering.
REQ-024 fn_sel changes after the first byte of a round SHALL be ignored until the next IDLE-to-COLLECT transition.
REQ-025 frame_rdy while frame_vld=0 SHALL have no effect.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, clear byte count, frame_idx and all data buffers to 0, and drive busy=0, frame_vld=0, last_frame=0, round_done=0, fn_cur=0, frame_data=0.
REQ-027 Reset mid-frame or mid-round SHALL discard the partial frame; the first accepted byte after release starts frame 0 of a new round.

Configuration
REQ-028 Macro IOT_FRAME_SCHED_DBLBUF_EN SHALL enable a second 128-bit assembly buffer.
REQ-029 With the macro, bytes SHALL continue into the second buffer during ISSUE; busy SHALL assert only when the second buffer holds 16 bytes and the issued frame is not yet accepted, or in DONE; on transfer a complete second buffer SHALL be presented the next cycle.
REQ-030 With the macro, no byte of the next round SHALL be accepted before round_done.
REQ-031 Without the macro, REQ-021 busy behaviour applies and the second buffer SHALL not exist.

Verification
REQ-032 Bytes 0x00..0x0F back-to-back, frame_rdy=1 -> frame_vld one cycle after byte 0x0F, frame_data=0x000102...0F, frame_idx=0.
REQ-033 Full round FRAMES=4, frame_rdy=1 -> frame_idx 0,1,2,3; last_frame only with idx 3; one round_done pulse; next byte restarts at idx 0.
REQ-034 frame_rdy held 0 for 10 cycles with in_en=1 -> frame_vld/frame_data stable, busy=1, no bytes consumed (non-buffered).
REQ-035 fn_sel=3 at first byte, switched to 5 mid-round -> fn_cur=3 for the whole round, 5 on the next round.
REQ-036 rst pulsed low after 7 bytes of frame 2 -> all outputs 0 immediately; next 16 bytes produce frame_idx=0.
REQ-037 DBLBUF build, frame_rdy stalled 20 cycles -> 16 further bytes accepted, then busy=1; second frame presented the cycle after the first transfer.

Source files
------------

// File: rtl/iot_frame_sched.sv
// iot_frame_sched: packs a byte stream into 128-bit frames and issues FRAMES frames per round.
// Ports: clk, rst (async, active-low); source side in_en/iot_in/busy; fn_sel latched per round
// as fn_cur; filter side frame_vld/frame_rdy/frame_data/frame_idx/last_frame; round_done pulse.
// Optional IOT_FRAME_SCHED_DBLBUF_EN: second assembly buffer keeps bytes flowing during issue.
module iot_frame_sched #(
   parameter int FRAMES = 96
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_en,
   input  logic [7:0]   iot_in,
   input  logic [2:0]   fn_sel,
   input  logic         frame_rdy,
   output logic         busy,
   output logic         frame_vld,
   output logic [127:0] frame_data,
   output logic [7:0]   frame_idx,
   output logic         last_frame,
   output logic [2:0]   fn_cur,
   output logic         round_done
);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, DONE} state_t;

   localparam logic [7:0] LAST = 8'(FRAMES - 1);

   state_t       state;
   state_t       state_nxt;
   logic [127:0] buf_a;
   logic [4:0]   cnt;
   logic [127:0] data_q;
   logic [7:0]   idx;
   logic [2:0]   fn_q;
   logic         take;
   logic         xfer;
   logic         is_last;
   logic [127:0] a_ins;

`ifdef IOT_FRAME_SCHED_DBLBUF_EN
   logic [127:0] buf_b;
   logic [4:0]   cnt_b;
   logic [127:0] b_nx;
   logic [4:0]   b_nx_cnt;
`endif

   // Byte n of a frame lands in lane n, counted from the top byte down.
   function automatic logic [127:0] put(
      input logic [127:0] b,
      input logic [4:0]   n,
      input logic [7:0]   d
   );
      logic [127:0] r;
      r = b;
      for (int i = 0; i < 16; i++)
         if (n == 5'(i)) r[8*(15-i) +: 8] = d;
      return r;
   endfunction

   assign take    = in_en && !busy;
   assign xfer    = (state == ISSUE) && frame_rdy;
   assign is_last = (idx == LAST);
   assign a_ins   = put(buf_a, cnt, iot_in);

`ifdef IOT_FRAME_SCHED_DBLBUF_EN
   assign b_nx     = take ? put(buf_b, cnt_b, iot_in) : buf_b;
   assign b_nx_cnt = take ? cnt_b + 5'd1 : cnt_b;
   // While the last frame of a round is out, hold off bytes of the next round.
   assign busy = (state == DONE)
              || ((state == ISSUE) && ((cnt_b == 5'd16) || is_last));
`else
   assign busy = (state == ISSUE) || (state == DONE);
`endif

   assign frame_vld  = (state == ISSUE);
   assign frame_data = data_q;
   assign frame_idx  = idx;
   assign last_frame = frame_vld && is_last;
   assign fn_cur     = fn_q;
   assign round_done = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (take) state_nxt = COLLECT;
         COLLECT: if (take && (cnt == 5'd15)) state_nxt = ISSUE;
         ISSUE: begin
            if (xfer) begin
               if (is_last)
                  state_nxt = DONE;
`ifdef IOT_FRAME_SCHED_DBLBUF_EN
               else if (b_nx_cnt != 5'd16)
                  state_nxt = COLLECT;
`else
               else
                  state_nxt = COLLECT;
`endif
            end
         end
         DONE:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_a  <= '0;
         cnt    <= '0;
         data_q <= '0;
         idx    <= '0;
         fn_q   <= '0;
`ifdef IOT_FRAME_SCHED_DBLBUF_EN
         buf_b  <= '0;
         cnt_b  <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  fn_q  <= fn_sel;
                  buf_a <= a_ins;
                  cnt   <= 5'd1;
               end
            end
            COLLECT: begin
               if (take) begin
                  if (cnt == 5'd15) begin
                     data_q <= a_ins;
                     cnt    <= '0;
                  end else begin
                     buf_a <= a_ins;
                     cnt   <= cnt + 5'd1;
                  end
               end
            end
            ISSUE: begin
`ifdef IOT_FRAME_SCHED_DBLBUF_EN
               if (xfer && !is_last) begin
                  idx   <= idx + 8'd1;
                  cnt_b <= '0;
                  // A full second buffer goes straight out; a partial one
                  // becomes the primary assembly buffer.
                  if (b_nx_cnt == 5'd16) begin
                     data_q <= b_nx;
                  end else begin
                     buf_a <= b_nx;
                     cnt   <= b_nx_cnt;
                  end
               end else begin
                  buf_b <= b_nx;
                  cnt_b <= b_nx_cnt;
               end
`else
               if (xfer && !is_last) idx <= idx + 8'd1;
`endif
            end
            DONE: idx <= '0;
         endcase
      end
   end

endmodule
